// File: rtl/miner_work_feeder.sv
// Work feeder between a word-serial job stream and a hashing core.
// Collects 11-word jobs into a shadow buffer and presents them to the miner.
// Queues found nonces, each tagged with its job id, in a two-entry result FIFO.
//
//   state   | meaning
//   COLLECT | no active job yet, gathering words of the first job
//   PRESENT | completed job offered on work_valid, input stalled
//   RUN     | miner busy on active job, next job gathered in shadow
module miner_work_feeder #(
  parameter logic [31:0] NONCE_START = 32'h0,
  parameter int          RES_DEPTH   = 2
) (
  input  logic         hash_clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic         work_valid,
  input  logic         work_ready,
  output logic [255:0] midstate,
  output logic [95:0]  data,
  output logic [31:0]  nonce_base,
  output logic [7:0]   job_id,
  input  logic         golden_valid,
  input  logic [31:0]  golden_nonce,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [31:0]  result_nonce,
  output logic [7:0]   result_job,
  output logic         err_frame,
  output logic [7:0]   drop_cnt
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PRESENT = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic [255:0]   shadow_mid_q, shadow_mid_d;
  logic [63:0]    shadow_data_q, shadow_data_d;
  logic [255:0]   midstate_q;
  logic [95:0]    data_q;
  logic [7:0]     job_id_q, next_id_q;
  logic           err_frame_q;
  logic [7:0]     drop_cnt_q;

  logic [39:0]    fifo_q [RES_DEPTH];
  logic           rd_ptr_q, wr_ptr_q;
  logic [1:0]     fcnt_q;

  logic           accept, last_word, job_done, frame_err;
  logic           push, pop, fifo_full, do_write, drop;

  assign in_ready   = (state_q != PRESENT);
  assign work_valid = (state_q == PRESENT);
  assign midstate   = midstate_q;
  assign data       = data_q;
  assign nonce_base = NONCE_START;
  assign job_id     = job_id_q;
  assign err_frame  = err_frame_q;
  assign drop_cnt   = drop_cnt_q;

  assign accept    = in_valid & in_ready;
  assign last_word = (wcnt_q == 4'd10);
  assign job_done  = accept & in_last & last_word;
  // in_last must coincide exactly with the eleventh word
  assign frame_err = accept & (in_last ^ last_word);

  assign result_valid = (fcnt_q != 2'd0);
  assign result_nonce = fifo_q[rd_ptr_q][39:8];
  assign result_job   = fifo_q[rd_ptr_q][7:0];

  assign pop       = result_valid & result_ready;
  assign push      = golden_valid & (state_q == RUN);
  assign fifo_full = (fcnt_q == 2'(RES_DEPTH));
  // a pop in the same cycle frees the slot the push lands in
  assign do_write  = push & (~fifo_full | pop);
  assign drop      = push & fifo_full & ~pop;

  // state register
  always_ff @(posedge hash_clk) begin
    if (!reset_n) state_q <= COLLECT;
    else          state_q <= state_d;
  end

  // next-state: a completed job always preempts to PRESENT
  always_comb begin
    state_d = state_q;
    case (state_q)
      PRESENT: if (work_ready) state_d = RUN;
      default: if (job_done)   state_d = PRESENT;
    endcase
  end

  // word counter and shadow loading
  always_comb begin
    wcnt_d        = wcnt_q;
    shadow_mid_d  = shadow_mid_q;
    shadow_data_d = shadow_data_q;
    if (frame_err || job_done) begin
      wcnt_d = 4'd0;
    end else if (accept) begin
      wcnt_d = wcnt_q + 4'd1;
      if (!wcnt_q[3]) shadow_mid_d[{wcnt_q[2:0], 5'b0} +: 32] = in_data;
      else            shadow_data_d[{wcnt_q[0], 5'b0} +: 32]   = in_data;
    end
  end

  // job buffers, active job outputs and framing error flag
  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      wcnt_q        <= 4'd0;
      shadow_mid_q  <= '0;
      shadow_data_q <= '0;
      midstate_q    <= '0;
      data_q        <= '0;
      job_id_q      <= 8'd0;
      next_id_q     <= 8'd0;
      err_frame_q   <= 1'b0;
    end else begin
      wcnt_q        <= wcnt_d;
      shadow_mid_q  <= shadow_mid_d;
      shadow_data_q <= shadow_data_d;
      if (job_done) begin
        midstate_q <= shadow_mid_q;
        data_q     <= {in_data, shadow_data_q};
        job_id_q   <= next_id_q;
        next_id_q  <= next_id_q + 8'd1;
      end
      if (frame_err) err_frame_q <= 1'b1;
    end
  end

  // result FIFO and saturating drop counter
  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < RES_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fcnt_q     <= 2'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (do_write) begin
        fifo_q[wr_ptr_q] <= {golden_nonce, job_id_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fcnt_q <= fcnt_q + {1'b0, do_write} - {1'b0, pop};
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_miner_work_feeder.sv
// Bench for miner_work_feeder: directed scenarios then random traffic,
// all compared against a queue-based model of the job and result rules.
module tb_miner_work_feeder;

  localparam logic [31:0] NS = 32'hA5A5_0001;

  logic         hash_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic         work_ready = 1'b0;
  logic         golden_valid = 1'b0;
  logic [31:0]  golden_nonce = '0;
  logic         result_ready = 1'b0;
  logic         in_ready, work_valid, result_valid, err_frame;
  logic [255:0] midstate;
  logic [95:0]  data;
  logic [31:0]  nonce_base, result_nonce;
  logic [7:0]   job_id, result_job, drop_cnt;

  miner_work_feeder #(.NONCE_START(NS), .RES_DEPTH(2)) dut (
    .hash_clk(hash_clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .work_valid(work_valid), .work_ready(work_ready),
    .midstate(midstate), .data(data), .nonce_base(nonce_base), .job_id(job_id),
    .golden_valid(golden_valid), .golden_nonce(golden_nonce),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_nonce(result_nonce), .result_job(result_job),
    .err_frame(err_frame), .drop_cnt(drop_cnt)
  );

  always #5 hash_clk = ~hash_clk;

  int total = 0;
  int bad = 0;

  // model: phase 0 = no job offered yet, 1 = job offered, 2 = miner running
  int           m_phase = 0;
  logic [31:0]  m_words[$];
  logic [39:0]  m_res[$];
  logic [255:0] m_mid = '0;
  logic [95:0]  m_data = '0;
  logic [7:0]   m_id = 8'd0;
  logic [7:0]   m_next = 8'd0;
  logic         m_err = 1'b0;
  int           m_drop = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance the model with the inputs present before the edge, then clock
  task automatic tick();
    if (!reset_n) begin
      m_phase = 0; m_words.delete(); m_res.delete();
      m_mid = '0; m_data = '0; m_id = 8'd0; m_next = 8'd0; m_err = 1'b0; m_drop = 0;
    end else begin
      if (result_ready && m_res.size() > 0) void'(m_res.pop_front());
      if (golden_valid && m_phase == 2) begin
        if (m_res.size() < 2) m_res.push_back({golden_nonce, m_id});
        else if (m_drop < 255) m_drop++;
      end
      if (m_phase == 1) begin
        if (work_ready) m_phase = 2;
      end else if (in_valid) begin
        m_words.push_back(in_data);
        if (m_words.size() == 11 && in_last) begin
          for (int k = 0; k < 8; k++) m_mid[32*k +: 32] = m_words[k];
          for (int k = 0; k < 3; k++) m_data[32*k +: 32] = m_words[8+k];
          m_id = m_next; m_next = m_next + 8'd1; m_phase = 1; m_words.delete();
        end else if (in_last || m_words.size() == 11) begin
          m_err = 1'b1; m_words.delete();
        end
      end
    end
    @(posedge hash_clk); #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":in_ready"}, in_ready, m_phase != 1);
    chk({tag, ":work_valid"}, work_valid, m_phase == 1);
    chk({tag, ":midstate"}, midstate, m_mid);
    chk({tag, ":data"}, data, m_data);
    chk({tag, ":nonce_base"}, nonce_base, NS);
    chk({tag, ":job_id"}, job_id, m_id);
    chk({tag, ":err_frame"}, err_frame, m_err);
    chk({tag, ":drop_cnt"}, drop_cnt, 8'(m_drop));
    chk({tag, ":result_valid"}, result_valid, m_res.size() > 0);
    if (m_res.size() > 0) begin
      chk({tag, ":result_nonce"}, result_nonce, m_res[0][39:8]);
      chk({tag, ":result_job"}, result_job, m_res[0][7:0]);
    end
  endtask

  task automatic stream_job(input string tag, input bit sequential, input int golden_at);
    for (int k = 0; k < 11; k++) begin
      in_valid = 1'b1;
      in_data = sequential ? 32'(k) : $urandom;
      in_last = (k == 10);
      golden_valid = (k == golden_at);
      golden_nonce = $urandom;
      tick();
      check_all(tag);
    end
    in_valid = 1'b0; in_last = 1'b0; golden_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    tick(); tick();
    check_all("reset");
    reset_n = 1'b1;
    tick();
    check_all("idle");

    // in_last on the sixth word is a framing error
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(k); in_last = (k == 5);
      tick();
      check_all("frame");
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("err_frame_set", err_frame, 1'b1);
    chk("no_work_after_err", work_valid, 1'b0);

    // clean job of words 0x00..0x0A
    stream_job("job0", 1'b1, -1);
    chk("job0_work_valid", work_valid, 1'b1);
    chk("job0_mid_lo", midstate[31:0], 32'h0);
    chk("job0_data_hi", data[95:64], 32'h0A);
    chk("job0_id", job_id, 8'd0);
    tick();
    check_all("job0_hold");
    work_ready = 1'b1;
    tick();
    work_ready = 1'b0;
    check_all("job0_run");

    golden_valid = 1'b1; golden_nonce = 32'hDEADBEEF;
    tick();
    golden_valid = 1'b0;
    chk("gold_valid", result_valid, 1'b1);
    chk("gold_nonce", result_nonce, 32'hDEADBEEF);
    chk("gold_job", result_job, 8'd0);

    for (int k = 0; k < 2; k++) begin
      golden_valid = 1'b1; golden_nonce = $urandom;
      tick();
      check_all("fill");
    end
    golden_valid = 1'b0;
    chk("full_drop", drop_cnt, 8'd1);
    chk("full_head", result_nonce, 32'hDEADBEEF);

    result_ready = 1'b1; golden_valid = 1'b1; golden_nonce = $urandom;
    tick();
    golden_valid = 1'b0;
    check_all("pushpop");
    chk("pushpop_drop", drop_cnt, 8'd1);
    tick(); check_all("drain1");
    tick(); check_all("drain2");
    chk("drained", result_valid, 1'b0);
    result_ready = 1'b0;

    // second job during RUN, golden on its completion cycle
    stream_job("job1", 1'b0, 10);
    chk("job1_work_valid", work_valid, 1'b1);
    chk("job1_id", job_id, 8'd1);
    chk("job1_gold_tag", result_job, 8'd0);

    // golden outside RUN is ignored
    golden_valid = 1'b1; golden_nonce = $urandom;
    tick();
    golden_valid = 1'b0;
    check_all("present_gold");
    work_ready = 1'b1;
    tick();
    work_ready = 1'b0;
    check_all("job1_run");
    golden_valid = 1'b1; golden_nonce = $urandom;
    tick();
    golden_valid = 1'b0;
    check_all("fill2");
    stream_job("job2", 1'b0, 0);
    chk("job2_present", work_valid, 1'b1);
    chk("job2_fifo_full", result_valid, 1'b1);

    reset_n = 1'b0;
    tick();
    chk("rst_work_valid", work_valid, 1'b0);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 8'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    check_all("rst_present");
    reset_n = 1'b1;

    for (int c = 0; c < 600; c++) begin
      reset_n = ($urandom_range(0, 249) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = $urandom;
      in_last = (m_words.size() == 10) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 29) == 0);
      work_ready = ($urandom_range(0, 3) == 0);
      golden_valid = ($urandom_range(0, 2) == 0);
      golden_nonce = $urandom;
      result_ready = ($urandom_range(0, 3) == 0);
      tick();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
